if_fetch_stage: RTL and testbench



---
 rtl/mips_pkg.sv | 19 +
 rtl/fetch_queue.sv | 63 ++++++
 rtl/if_fetch_stage.sv | 101 ++++++++++
 tb/tb_if_fetch_stage.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared fetch/decode definitions: word type, instruction size, immediate
// field position and the entry layout carried from fetch to decode.
package mips_pkg;

   typedef logic [31:0] word_t;

   localparam word_t INSTR_BYTES   = 32'd4;
   localparam word_t PC_ALIGN_MASK = 32'hFFFF_FFFC;

   // 16-bit immediate field, also used by the sign extender
   localparam int IMM_LSB = 0;
   localparam int IMM_MSB = 15;

   typedef struct packed {
      word_t pc;
      word_t instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO with flush. Head is presented combinationally and
// reads as zero when empty so downstream fields have a defined idle value.
module fetch_queue
   import mips_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   output logic [WIDTH-1:0]             head,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [AW-1:0] LAST     = AW'(DEPTH-1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr, wr_ptr;
   logic             full, do_push, do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign do_pop  = pop && !empty;
   // a full queue may still take a push when the head leaves the same cycle
   assign do_push = push && (!full || do_pop);
   assign head    = empty ? '0 : mem[rd_ptr];

   // pointer and occupancy tracking; flush drops everything
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // storage needs no reset; the head mux hides stale contents
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

`ifndef SYNTHESIS
   // upstream credit accounting must never let a push land on a full queue
   assert property (@(posedge clk) disable iff (rst) !(push && full && !pop && !flush));
`endif

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: PC register, credit-limited request issue, PC tag
// tracking for in-order responses, instruction buffering toward decode and
// redirect handling that squashes fetches already in flight.
module if_fetch_stage
   import mips_pkg::*;
#(
   parameter word_t RESET_PC        = 32'h0000_0000,
   parameter int    MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc_plus4,
   output logic [15:0] id_imm16
);

   localparam int CW = $clog2(MAX_OUTSTANDING+1);
   localparam logic [CW:0] CREDITS = (CW+1)'(MAX_OUTSTANDING);

   word_t           pc;
   logic [CW-1:0]   drop_cnt;
   logic [CW-1:0]   tag_cnt, q_cnt;
   logic [CW:0]     credit_used;
   logic            tag_empty, q_empty;
   logic [31:0]     tag_head;
   logic [63:0]     q_head_raw;
   fetch_entry_t    q_head, rsp_entry;
   logic            req_fire, rsp_take, rsp_keep, id_fire;

   // tag FIFO occupancy is exactly the number of requests still in flight
   assign credit_used    = {1'b0, tag_cnt} + {1'b0, q_cnt};
   assign imem_req_valid = !rst && !redirect_valid && (credit_used < CREDITS);
   assign imem_addr      = pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // a response with no matching tag predates reset and is ignored
   assign rsp_take = imem_rsp_valid && !tag_empty;
   assign rsp_keep = rsp_take && (drop_cnt == '0) && !redirect_valid;

   assign rsp_entry.pc    = tag_head;
   assign rsp_entry.instr = imem_rsp_data;

   assign q_head      = fetch_entry_t'(q_head_raw);
   assign id_valid    = !q_empty;
   assign id_fire     = id_valid && id_ready;
   assign id_instr    = q_head.instr;
   assign id_pc       = q_head.pc;
   assign id_pc_plus4 = q_head.pc + INSTR_BYTES;
   assign id_imm16    = q_head.instr[IMM_MSB:IMM_LSB];

   // PC advance and stale-response bookkeeping; redirect overrides both
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc       <= RESET_PC;
         drop_cnt <= '0;
      end else if (redirect_valid) begin
         pc       <= redirect_target & PC_ALIGN_MASK;
         // everything still in flight after this cycle's response is stale
         drop_cnt <= tag_cnt - CW'(rsp_take);
      end else begin
         if (req_fire) pc <= pc + INSTR_BYTES;
         if (rsp_take && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
      end
   end

   // tags survive redirects: dropped responses still need their tag popped
   fetch_queue #(.DEPTH(MAX_OUTSTANDING), .WIDTH(32)) u_tag_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (1'b0),
      .push      (req_fire),
      .push_data (pc),
      .pop       (rsp_take),
      .head      (tag_head),
      .count     (tag_cnt),
      .empty     (tag_empty)
   );

   fetch_queue #(.DEPTH(MAX_OUTSTANDING), .WIDTH(64)) u_instr_q (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect_valid),
      .push      (rsp_keep),
      .push_data (rsp_entry),
      .pop       (id_fire),
      .head      (q_head_raw),
      .count     (q_cnt),
      .empty     (q_empty)
   );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a simple in-order memory model of
// configurable latency.
module tb_if_fetch_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b1;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_target = '0;
   logic        id_valid;
   logic        id_ready = 1'b0;
   logic [31:0] id_instr, id_pc, id_pc_plus4;
   logic [15:0] id_imm16;

   int n_cmp = 0;
   int n_fail = 0;
   int lat = 1;
   int acc_cnt = 0;
   int edges = 0;

   typedef struct { logic [31:0] addr; int due; } pend_t;
   pend_t pend[$];

   if_fetch_stage dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
      .id_pc_plus4(id_pc_plus4), .id_imm16(id_imm16)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h2008_FFFF;
      if (a == 32'h4) return 32'h2009_0010;
      return {16'hC0DE, a[15:0]};
   endfunction

   always @(posedge clk) edges <= edges + 1;

   // memory: decides at the falling edge what the next rising edge sees
   always @(negedge clk) begin
      if (rst) begin
         pend.delete();
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = '0;
      end else begin
         if (pend.size() > 0 && pend[0].due <= edges + 1) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend[0].addr);
            void'(pend.pop_front());
         end else begin
            imem_rsp_valid = 1'b0;
         end
         if (imem_req_valid && imem_req_ready) begin
            pend.push_back('{imem_addr, edges + 1 + lat});
            acc_cnt++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; redirect_valid = 1'b0; redirect_target = '0; imem_req_ready = 1'b1; lat = 1;
      tick(); tick(); tick();
      rst = 1'b0; #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; id_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid: got %b exp 0", imem_req_valid); end
         n_cmp++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rst_id_valid: got %b exp 0", id_valid); end
         n_cmp++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h exp 0", imem_addr); end
      end
      n_cmp++; if (id_pc_plus4 !== 32'h4) begin n_fail++; $display("FAIL rst_pc_plus4: got %h exp 4", id_pc_plus4); end
      n_cmp++; if ({id_instr, id_pc, id_imm16} !== '0) begin n_fail++; $display("FAIL rst_id_fields: got %h %h %h exp 0", id_instr, id_pc, id_imm16); end
      rst = 1'b0; #1;
      n_cmp++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL first_req: got v=%b a=%h exp v=1 a=0", imem_req_valid, imem_addr); end
      tick();
      n_cmp++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h4) begin n_fail++; $display("FAIL second_req: got v=%b a=%h exp v=1 a=4", imem_req_valid, imem_addr); end
      n_cmp++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL early_id_valid: got %b exp 0", id_valid); end
      tick();
      n_cmp++; if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL third_addr: got %h exp 8", imem_addr); end
      n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'h0) begin n_fail++; $display("FAIL first_id: got v=%b pc=%h exp v=1 pc=0", id_valid, id_pc); end
      // reset mid-operation clears everything immediately
      rst = 1'b1; #1;
      n_cmp++; if (id_valid !== 1'b0 || imem_req_valid !== 1'b0 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL midop_reset: got idv=%b rv=%b a=%h exp 0 0 0", id_valid, imem_req_valid, imem_addr); end
   endtask

   task automatic test_stream();
      id_ready = 1'b1;
      do_reset();
      tick(); tick();
      n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== 32'h2008_FFFF) begin n_fail++; $display("FAIL stream0: got v=%b pc=%h i=%h exp v=1 pc=0 i=2008ffff", id_valid, id_pc, id_instr); end
      n_cmp++; if (id_imm16 !== 16'hFFFF || id_pc_plus4 !== 32'h4) begin n_fail++; $display("FAIL stream0_fields: got imm=%h p4=%h exp ffff 4", id_imm16, id_pc_plus4); end
      tick();
      n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'h4 || id_instr !== 32'h2009_0010) begin n_fail++; $display("FAIL stream1: got v=%b pc=%h i=%h exp v=1 pc=4 i=20090010", id_valid, id_pc, id_instr); end
      n_cmp++; if (id_imm16 !== 16'h0010 || id_pc_plus4 !== 32'h8) begin n_fail++; $display("FAIL stream1_fields: got imm=%h p4=%h exp 0010 8", id_imm16, id_pc_plus4); end
   endtask

   task automatic test_backpressure();
      int a0, got;
      logic [31:0] exp_pc;
      id_ready = 1'b0;
      do_reset();
      a0 = acc_cnt;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (i >= 1) begin
            n_cmp++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_credit%0d: got %b exp 0", i, imem_req_valid); end
         end
      end
      n_cmp++; if (acc_cnt - a0 !== 2) begin n_fail++; $display("FAIL bp_outstanding: got %0d exp 2", acc_cnt - a0); end
      n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'h0) begin n_fail++; $display("FAIL bp_head: got v=%b pc=%h exp v=1 pc=0", id_valid, id_pc); end
      id_ready = 1'b1; exp_pc = 32'h0; got = 0;
      for (int i = 0; i < 12; i++) begin
         if (id_valid) begin
            n_cmp++; if (id_pc !== exp_pc) begin n_fail++; $display("FAIL bp_order: got %h exp %h", id_pc, exp_pc); end
            exp_pc += 32'h4; got++;
         end
         tick();
      end
      n_cmp++; if (got < 6) begin n_fail++; $display("FAIL bp_drain_count: got %0d exp >=6", got); end
   endtask

   task automatic test_redirect_inflight();
      bit seen_req, done;
      id_ready = 1'b1;
      do_reset();
      lat = 3;
      tick(); tick();
      redirect_valid = 1'b1; redirect_target = 32'h0000_0103; #1;
      n_cmp++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rdi_req_in_redirect: got %b exp 0", imem_req_valid); end
      tick();
      redirect_valid = 1'b0; #1;
      n_cmp++; if (imem_addr !== 32'h100 || id_valid !== 1'b0) begin n_fail++; $display("FAIL rdi_pc: got a=%h v=%b exp a=100 v=0", imem_addr, id_valid); end
      seen_req = 0; done = 0;
      for (int i = 0; i < 20 && !done; i++) begin
         if (imem_req_valid && imem_req_ready && !seen_req) begin
            seen_req = 1;
            n_cmp++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL rdi_first_req: got %h exp 100", imem_addr); end
         end
         if (id_valid) begin
            done = 1;
            n_cmp++; if (id_pc !== 32'h100 || id_instr !== 32'hC0DE_0100) begin n_fail++; $display("FAIL rdi_first_id: got pc=%h i=%h exp 100 c0de0100", id_pc, id_instr); end
         end else tick();
      end
      n_cmp++; if (!done) begin n_fail++; $display("FAIL rdi_timeout: got no id_valid exp one within 20 cycles"); end
   endtask

   task automatic test_redirect_rsp();
      bit done;
      id_ready = 1'b1;
      do_reset();
      tick(); tick();
      // head at pc 0 is being consumed and the pc 4 response lands this edge
      redirect_valid = 1'b1; redirect_target = 32'h0000_0200; #1;
      n_cmp++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rdr_req: got %b exp 0", imem_req_valid); end
      tick();
      redirect_valid = 1'b0; #1;
      n_cmp++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rdr_flush: got %b exp 0", id_valid); end
      n_cmp++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h200) begin n_fail++; $display("FAIL rdr_next_req: got v=%b a=%h exp v=1 a=200", imem_req_valid, imem_addr); end
      done = 0;
      for (int i = 0; i < 10 && !done; i++) begin
         if (id_valid) begin
            done = 1;
            n_cmp++; if (id_pc !== 32'h200 || id_instr !== 32'hC0DE_0200) begin n_fail++; $display("FAIL rdr_first_id: got pc=%h i=%h exp 200 c0de0200", id_pc, id_instr); end
         end else tick();
      end
      n_cmp++; if (!done) begin n_fail++; $display("FAIL rdr_timeout: got no id_valid exp one within 10 cycles"); end
   endtask

   task automatic test_wrap();
      id_ready = 1'b0;
      do_reset();
      redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC; #1;
      n_cmp++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_req_in_redirect: got %b exp 0", imem_req_valid); end
      tick();
      redirect_valid = 1'b0; #1;
      n_cmp++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_req0: got v=%b a=%h exp v=1 a=fffffffc", imem_req_valid, imem_addr); end
      tick();
      n_cmp++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_req1: got v=%b a=%h exp v=1 a=0", imem_req_valid, imem_addr); end
      tick();
      n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_id: got v=%b pc=%h exp v=1 pc=fffffffc", id_valid, id_pc); end
      n_cmp++; if (id_pc_plus4 !== 32'h0 || id_imm16 !== 16'hFFFC) begin n_fail++; $display("FAIL wrap_fields: got p4=%h imm=%h exp 0 fffc", id_pc_plus4, id_imm16); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_inflight();
      test_redirect_rsp();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
